// File: rtl/btn_pkg.sv
// btn_pkg: shared types and defaults for the pushbutton input path.
//   btn_state_t             - per-channel debounce FSM state
//   DEFAULT_DEBOUNCE_CYCLES - 10 ms stability window at 12 MHz
//   DEFAULT_LONG_CYCLES     - 1 s long-press hold at 12 MHz
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 120000;
  localparam int unsigned DEFAULT_LONG_CYCLES     = 12000000;

endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one pushbutton channel.
//   The raw pin passes through a 2-FF synchronizer, is normalised to
//   1 = pressed, and is then filtered by a counter-based debounce FSM
//   that emits registered level and single-cycle press/release pulses.
// Optional feature macro: BTN_LONG_PRESS_EN adds a hold counter and a
//   single-cycle o_long pulse; otherwise o_long is tied 0.
// Ports:
//   i_clk     - system clock
//   i_rst     - synchronous, active-high reset
//   i_btn     - raw asynchronous pin level
//   o_level   - debounced state, 1 = pressed
//   o_press   - 1-cycle pulse on accepted press
//   o_release - 1-cycle pulse on accepted release
//   o_long    - 1-cycle long-press pulse
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int unsigned CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic        REL_LVL = (ACTIVE_LOW != 0);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("btn_debounce_ch: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("btn_debounce_ch: LONG_CYCLES must be >= 1");
  end

  logic          r_s0;
  logic          r_s1;
  btn_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;
  logic          r_release;

  logic w_p;
  logic w_cnt_done;
  logic w_press_done;
  logic w_release_done;

  assign w_p            = r_s1 ^ REL_LVL;
  assign w_cnt_done     = (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign w_press_done   = (r_state == PRESS_WAIT)   &&  w_p && w_cnt_done;
  assign w_release_done = (r_state == RELEASE_WAIT) && !w_p && w_cnt_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s0      <= REL_LVL;
      r_s1      <= REL_LVL;
      r_state   <= RELEASED;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_s0      <= i_btn;
      r_s1      <= r_s0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        RELEASED: begin
          if (w_p) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!w_p) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
          end else if (w_press_done) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!w_p) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= CW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (w_p) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end else if (w_release_done) begin
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= RELEASED;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);

  logic [HW-1:0] r_hold;
  logic          r_long;

  // Hold count saturates at LONG_CYCLES so the pulse fires once per press;
  // counting stops on the edge a release is accepted, so a release that
  // wins the race suppresses the long pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (w_press_done) begin
        r_hold <= '0;
      end else if (((r_state == PRESSED) || (r_state == RELEASE_WAIT)) &&
                   !w_release_done && (r_hold != HW'(LONG_CYCLES))) begin
        r_hold <= r_hold + 1'b1;
        if (r_hold == HW'(LONG_CYCLES - 1)) begin
          r_long <= 1'b1;
        end
      end
    end
  end

  assign o_long = r_long;
`else
  assign o_long = 1'b0;
`endif

endmodule

// File: rtl/btn_input.sv
// btn_input: conditions N_BTN raw pushbutton/switch pins into clean,
//   clock-domain-safe levels and event pulses (one btn_debounce_ch per pin).
// Optional feature macro: BTN_LONG_PRESS_EN enables btn_long pulses;
//   otherwise btn_long is constant 0.
// Ports:
//   clk         - system clock
//   rst         - synchronous, active-high reset
//   btn_in      - raw asynchronous pin levels
//   btn_level   - debounced state, 1 = pressed
//   btn_press   - 1-cycle pulse per accepted press
//   btn_release - 1-cycle pulse per accepted release
//   btn_long    - 1-cycle long-press pulse
module btn_input
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_btn     (btn_in[g]),
      .o_level   (btn_level[g]),
      .o_press   (btn_press[g]),
      .o_release (btn_release[g]),
      .o_long    (btn_long[g])
    );
  end

endmodule
